wb_mux_arbiter: RTL and testbench
=================================

Name: wb_mux_arbiter

Overview:
- Two-requester round-robin arbiter that owns the select line of the shared 2:1 write-back mux in the miniRISC datapath.
- Grants one source at a time to a single downstream resource (register-file write port or memory port).
- Supports multi-beat bursts with a valid/ready handshake.
- A programmable burst cap forces re-arbitration so neither requester can starve the other.

Parameters:
DATA_W, 32, width of each requester's data bus and of the muxed output
MAX_BURST, 8, maximum beats per grant before forced release (must be >= 1)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous, active-high reset
req0  input  1  requester 0 has a valid beat
data0  input  DATA_W  requester 0 beat data
last0  input  1  final beat of requester 0 burst
gnt0  output  1  requester 0 beat accepted this cycle
req1  input  1  requester 1 has a valid beat
data1  input  DATA_W  requester 1 beat data
last1  input  1  final beat of requester 1 burst
gnt1  output  1  requester 1 beat accepted this cycle
sel  output  1  mux select line: 0 = source 0, 1 = source 1
out_valid  output  1  beat presented to resource
out_data  output  DATA_W  muxed data
out_last  output  1  muxed last flag
out_ready  input  1  resource accepts beat

Behaviour:
- Reset values:
  - State IDLE.
  - sel=0, gnt0=gnt1=0, out_valid=0, out_data=0, out_last=0.
  - rr_ptr=0 (requester 0 has priority first).
  - beat_cnt=0.
- State register: IDLE, GRANT0, GRANT1. beat_cnt is $clog2(MAX_BURST)+1 bits wide. sel is registered.
- IDLE:
  - out_valid=0, gnt*=0, out_data=0.
  - sel holds its last value; it never toggles while idle.
  - If req0 and req1 are both high, grant goes to the requester indexed by rr_ptr.
  - If only one is high, grant goes to that one.
  - Next state is GRANTx, with sel<=x and beat_cnt<=0.
  - Latency: req high in cycle N -> out_valid high in cycle N+1.
- GRANTx (combinational outputs from registered state):
  - out_valid=reqx, out_data=datax, out_last=lastx.
  - gntx = reqx & out_ready; gnt of the other requester = 0.
  - A transfer occurs when out_valid & out_ready.
- Backpressure:
  - While out_ready=0 there is no transfer and beat_cnt is unchanged.
  - The requester must hold reqx, datax and lastx stable.
- Release:
  - Release happens on a transfer with lastx=1, or on a transfer with beat_cnt==MAX_BURST-1 (forced).
  - On release: rr_ptr<=~x.
  - If the other requester's req is high in the same cycle, next state is the other GRANT, sel<=~x, beat_cnt<=0. There is no idle bubble.
  - Otherwise next state is IDLE.
  - A forced release with no competitor goes to IDLE; the requester is re-granted one cycle later.
- Non-release transfer: beat_cnt<=beat_cnt+1.
- Lock rule:
  - A granted requester that drops req mid-burst keeps the grant with out_valid=0.
  - The other requester waits.
  - Protocol requirement: requesters keep req high until their last beat.
- sel changes only on a clock edge entering a GRANT state. It is glitch-free to the mux.
- MAX_BURST=1: every transfer is a release. Continuous dual requests alternate every beat.
- Simultaneous release and new request by the same requester with no competitor: the arbiter goes to IDLE, then re-grants.
- Reset mid-burst:
  - On the next edge all state and outputs return to reset values.
  - The in-flight beat is dropped and gnt is not asserted in the reset cycle.
  - rst has priority over all other inputs.
- gnt0 and gnt1 are never high together. out_valid is never high in IDLE.

Test Plan:
1. Reset; req0=1 with 3-beat burst (data 0xA1,0xA2,0xA3, last on beat 3), out_ready=1 -> sel=0; out_valid high cycles 1-3 with matching out_data; gnt0 high 3 cycles; IDLE in cycle 4; rr_ptr=1.
2. After reset, req0 and req1 both asserted, single-beat bursts with last=1 -> GRANT0 first, then GRANT1 on the very next cycle (no bubble); sel 0->1; rr_ptr ends at 0.
3. MAX_BURST=4; req0 8-beat burst with req1 pending (2 beats) -> 4 beats of req0, then 2 beats of req1, then remaining 4 beats of req0; sel 0,1,0.
4. In GRANT0, out_ready=0 for 2 cycles mid-burst -> out_valid=1, out_data stable, gnt0=0, beat_cnt frozen; transfer resumes on out_ready=1.
5. rst asserted on beat 2 of a GRANT1 burst -> next cycle sel=0, out_valid=0, gnt1=0, state IDLE; a later simultaneous req0/req1 grants requester 0 first.
6. MAX_BURST=1, req0 and req1 held high with last=0 -> sel toggles every transfer cycle; gnt0 and gnt1 alternate; never both high.

Source files
------------

// File: rtl/wb_mux_arbiter_if.sv
// rtl/wb_mux_arbiter_if.sv - requester/resource bundle around the write-back mux arbiter
interface wb_mux_arbiter_if #(
  parameter int DATA_W = 32
);
  logic              req0;
  logic [DATA_W-1:0] data0;
  logic              last0;
  logic              gnt0;
  logic              req1;
  logic [DATA_W-1:0] data1;
  logic              last1;
  logic              gnt1;
  logic              sel;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready;

  // Arbiter side: drives grants, select and the muxed beat
  modport master (
    input  req0, data0, last0, req1, data1, last1, out_ready,
    output gnt0, gnt1, sel, out_valid, out_data, out_last
  );

  // Environment side: requesters plus the downstream resource
  modport slave (
    output req0, data0, last0, req1, data1, last1, out_ready,
    input  gnt0, gnt1, sel, out_valid, out_data, out_last
  );
endinterface

// File: rtl/wb_mux_arbiter.sv
// rtl/wb_mux_arbiter.sv - two-requester round-robin burst arbiter driving the write-back mux select
module wb_mux_arbiter #(
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 8
) (
  input  logic             clk,
  input  logic             rst,
  wb_mux_arbiter_if.master bus
);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;

  state_t           state;
  logic             sel_q;
  logic             rr_ptr;
  logic [CNT_W-1:0] beat_cnt;

  logic in_grant;
  logic cur;
  logic cur_req;
  logic cur_last;
  logic other_req;
  logic xfer;
  logic release_now;
  logic pick;

  // Decode the granted source, detect transfers and burst release, and pick the next winner from idle
  always_comb begin
    in_grant    = (state == GRANT0) || (state == GRANT1);
    cur         = (state == GRANT1);
    cur_req     = cur ? bus.req1  : bus.req0;
    cur_last    = cur ? bus.last1 : bus.last0;
    other_req   = cur ? bus.req0  : bus.req1;
    xfer        = in_grant && cur_req && bus.out_ready;
    release_now = xfer && (cur_last || (beat_cnt == CNT_W'(MAX_BURST - 1)));
    pick        = (bus.req0 && bus.req1) ? rr_ptr : bus.req1;
  end

  // Present the owner's beat; grants and valid are held low during reset so an in-flight beat is dropped
  always_comb begin
    bus.sel       = sel_q;
    bus.gnt0      = 1'b0;
    bus.gnt1      = 1'b0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    bus.out_last  = 1'b0;
    if (in_grant) begin
      bus.out_valid = cur_req && !rst;
      bus.out_data  = cur ? bus.data1 : bus.data0;
      bus.out_last  = cur_last;
      bus.gnt0      = !cur && xfer && !rst;
      bus.gnt1      = cur && xfer && !rst;
    end
  end

  // Arbitration FSM: grant from idle, count beats, release on last or burst cap, hand over without a bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      sel_q    <= 1'b0;
      rr_ptr   <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0 || bus.req1) begin
            state    <= pick ? GRANT1 : GRANT0;
            sel_q    <= pick;
            beat_cnt <= '0;
          end
        end
        GRANT0, GRANT1: begin
          if (release_now) begin
            rr_ptr <= !cur;
            if (other_req) begin
              state    <= cur ? GRANT0 : GRANT1;
              sel_q    <= !cur;
              beat_cnt <= '0;
            end else begin
              state <= IDLE;
            end
          end else if (xfer) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wb_mux_arbiter.sv
// tb/tb_wb_mux_arbiter.sv - directed bench for wb_mux_arbiter
module tb_wb_mux_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_mux_arbiter_if #(.DATA_W(32)) b8 ();
  wb_mux_arbiter_if #(.DATA_W(32)) b4 ();
  wb_mux_arbiter_if #(.DATA_W(32)) b1 ();

  wb_mux_arbiter #(.DATA_W(32), .MAX_BURST(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8.master));
  wb_mux_arbiter #(.DATA_W(32), .MAX_BURST(4)) u_dut4 (.clk(clk), .rst(rst), .bus(b4.master));
  wb_mux_arbiter #(.DATA_W(32), .MAX_BURST(1)) u_dut1 (.clk(clk), .rst(rst), .bus(b1.master));

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        r;
    logic        q0;
    logic [31:0] d0;
    logic        l0;
    logic        q1;
    logic [31:0] d1;
    logic        l1;
    logic        rdy;
    logic [36:0] exp;  // {gnt0, gnt1, sel, out_valid, out_last, out_data}
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(logic r, logic q0, logic [31:0] d0, logic l0,
                              logic q1, logic [31:0] d1, logic l1, logic rdy,
                              logic g0, logic g1, logic s, logic ov, logic ol, logic [31:0] od);
    vec_t v;
    v.r = r; v.q0 = q0; v.d0 = d0; v.l0 = l0;
    v.q1 = q1; v.d1 = d1; v.l1 = l1; v.rdy = rdy;
    v.exp = {g0, g1, s, ov, ol, od};
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_all();
    b8.req0 = 0; b8.data0 = 0; b8.last0 = 0; b8.req1 = 0; b8.data1 = 0; b8.last1 = 0; b8.out_ready = 0;
    b4.req0 = 0; b4.data0 = 0; b4.last0 = 0; b4.req1 = 0; b4.data1 = 0; b4.last1 = 0; b4.out_ready = 0;
    b1.req0 = 0; b1.data0 = 0; b1.last0 = 0; b1.req1 = 0; b1.data1 = 0; b1.last1 = 0; b1.out_ready = 0;
  endtask

  task automatic do_reset();
    idle_all();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  logic [31:0] exp_data[10] = '{32'h100, 32'h101, 32'h102, 32'h103, 32'h200,
                                32'h201, 32'h104, 32'h105, 32'h106, 32'h107};
  logic        exp_src[10]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

  initial begin
    // reset, 3-beat burst, dual single beats, backpressure, lock, reset mid-burst
    vecs[0]  = mk(1, 0, 0,      0, 0, 0,      0, 0,  0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 32'hA1, 0, 0, 0,      0, 1,  0, 0, 0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 32'hA1, 0, 0, 0,      0, 1,  1, 0, 0, 1, 0, 32'hA1);
    vecs[3]  = mk(0, 1, 32'hA2, 0, 0, 0,      0, 1,  1, 0, 0, 1, 0, 32'hA2);
    vecs[4]  = mk(0, 1, 32'hA3, 1, 0, 0,      0, 1,  1, 0, 0, 1, 1, 32'hA3);
    vecs[5]  = mk(0, 0, 0,      0, 0, 0,      0, 1,  0, 0, 0, 0, 0, 0);
    vecs[6]  = mk(1, 0, 0,      0, 0, 0,      0, 1,  0, 0, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 32'hB0, 1, 1, 32'hC0, 1, 1,  0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(0, 1, 32'hB0, 1, 1, 32'hC0, 1, 1,  1, 0, 0, 1, 1, 32'hB0);
    vecs[9]  = mk(0, 0, 0,      0, 1, 32'hC0, 1, 1,  0, 1, 1, 1, 1, 32'hC0);
    vecs[10] = mk(0, 0, 0,      0, 0, 0,      0, 1,  0, 0, 1, 0, 0, 0);
    vecs[11] = mk(0, 1, 32'hD0, 0, 0, 0,      0, 1,  0, 0, 1, 0, 0, 0);
    vecs[12] = mk(0, 1, 32'hD0, 0, 0, 0,      0, 1,  1, 0, 0, 1, 0, 32'hD0);
    vecs[13] = mk(0, 1, 32'hD1, 0, 0, 0,      0, 0,  0, 0, 0, 1, 0, 32'hD1);
    vecs[14] = mk(0, 1, 32'hD1, 0, 0, 0,      0, 0,  0, 0, 0, 1, 0, 32'hD1);
    vecs[15] = mk(0, 1, 32'hD1, 0, 0, 0,      0, 1,  1, 0, 0, 1, 0, 32'hD1);
    vecs[16] = mk(0, 1, 32'hD2, 1, 0, 0,      0, 1,  1, 0, 0, 1, 1, 32'hD2);
    vecs[17] = mk(0, 0, 0,      0, 1, 32'hE0, 0, 1,  0, 0, 0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0,      0, 1, 32'hE0, 0, 1,  0, 1, 1, 1, 0, 32'hE0);
    vecs[19] = mk(0, 1, 32'hF0, 0, 0, 32'hE1, 0, 1,  0, 0, 1, 0, 0, 32'hE1);
    vecs[20] = mk(1, 1, 32'hF0, 0, 1, 32'hE1, 0, 1,  0, 0, 1, 0, 0, 32'hE1);
    vecs[21] = mk(0, 1, 32'hF0, 1, 1, 32'h5A, 1, 1,  0, 0, 0, 0, 0, 0);
    vecs[22] = mk(0, 1, 32'hF0, 1, 1, 32'h5A, 1, 1,  1, 0, 0, 1, 1, 32'hF0);
    vecs[23] = mk(0, 0, 0,      0, 1, 32'h5A, 1, 1,  0, 1, 1, 1, 1, 32'h5A);
    vecs[24] = mk(0, 0, 0,      0, 0, 0,      0, 1,  0, 0, 1, 0, 0, 0);

    idle_all();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      rst = vecs[i].r;
      b8.req0 = vecs[i].q0; b8.data0 = vecs[i].d0; b8.last0 = vecs[i].l0;
      b8.req1 = vecs[i].q1; b8.data1 = vecs[i].d1; b8.last1 = vecs[i].l1;
      b8.out_ready = vecs[i].rdy;
      @(negedge clk);
      check($sformatf("vec%0d {gnt0,gnt1,sel,valid,last,data}", i),
            64'({b8.gnt0, b8.gnt1, b8.sel, b8.out_valid, b8.out_last, b8.out_data}),
            64'(vecs[i].exp));
      @(posedge clk);
      #1;
    end

    // burst cap of 4 with a stall: 4 beats of req0, 2 of req1, then the rest of req0
    do_reset();
    begin
      int idx0 = 0;
      int idx1 = 0;
      int k = 0;
      for (int c = 0; c < 30; c++) begin
        b4.req0 = (idx0 < 8); b4.data0 = 32'h100 + 32'(idx0); b4.last0 = (idx0 == 7);
        b4.req1 = (idx1 < 2); b4.data1 = 32'h200 + 32'(idx1); b4.last1 = (idx1 == 1);
        b4.out_ready = !(c == 2 || c == 3);
        @(negedge clk);
        if (b4.gnt0 && b4.gnt1) check($sformatf("cap4 both gnt c%0d", c), 64'(1), 64'(0));
        if (b4.gnt0 || b4.gnt1) begin
          if (k < 10) begin
            check($sformatf("cap4 src k%0d", k), 64'(b4.gnt1), 64'(exp_src[k]));
            check($sformatf("cap4 sel k%0d", k), 64'(b4.sel), 64'(exp_src[k]));
            check($sformatf("cap4 data k%0d", k), 64'(b4.out_data), 64'(exp_data[k]));
            check($sformatf("cap4 cycle k%0d", k), 64'(c), 64'((k == 0) ? 1 : k + 3));
          end
          k++;
          if (b4.gnt0) idx0++; else idx1++;
        end
        @(posedge clk);
        #1;
      end
      check("cap4 transfer count", 64'(k), 64'(10));
    end
    idle_all();

    // burst cap of 1: dual requests alternate every beat
    do_reset();
    for (int c = 0; c < 10; c++) begin
      b1.req0 = 1; b1.data0 = 32'h11; b1.last0 = 0;
      b1.req1 = 1; b1.data1 = 32'h22; b1.last1 = 0;
      b1.out_ready = 1;
      @(negedge clk);
      check($sformatf("cap1 alt gnt0 c%0d", c), 64'(b1.gnt0), 64'(c % 2 == 1));
      check($sformatf("cap1 alt gnt1 c%0d", c), 64'(b1.gnt1), 64'(c != 0 && c % 2 == 0));
      check($sformatf("cap1 alt sel c%0d", c), 64'(b1.sel), 64'(c != 0 && c % 2 == 0));
      check($sformatf("cap1 alt both c%0d", c), 64'(b1.gnt0 && b1.gnt1), 64'(0));
      @(posedge clk);
      #1;
    end

    // burst cap of 1, lone requester: every forced release passes through idle
    do_reset();
    for (int c = 0; c < 6; c++) begin
      b1.req0 = 1; b1.data0 = 32'h33; b1.last0 = 0;
      b1.out_ready = 1;
      @(negedge clk);
      check($sformatf("cap1 solo gnt0 c%0d", c), 64'(b1.gnt0), 64'(c % 2 == 1));
      check($sformatf("cap1 solo valid c%0d", c), 64'(b1.out_valid), 64'(c % 2 == 1));
      @(posedge clk);
      #1;
    end
    idle_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
